// File: rtl/alu_pipe_arbiter_pkg.sv
// Shared types for the two-requester pipelined ALU: requester id, latency and
// round-robin pointer encoding.
package alu_pipe_arbiter_pkg;

    localparam int LAT_CYCLES = 3;

    typedef logic req_id_t;

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } ptr_state_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/alu_pipe_dp.sv
// Three-stage datapath computing F = ((a+b) + (c-d)) * d modulo 2^N.
// Each stage loads only when its input stage holds a live operation, so the
// final register keeps the last result between strobes.
module alu_pipe_dp #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_en,
    input  logic         s1_en,
    input  logic         s2_en,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
    output logic [N-1:0] f
);

    logic [N-1:0] s1_ab;
    logic [N-1:0] s1_cd;
    logic [N-1:0] s1_d;
    logic [N-1:0] s2_sum;
    logic [N-1:0] s2_d;
    logic [N-1:0] s3_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ab  <= '0;
            s1_cd  <= '0;
            s1_d   <= '0;
            s2_sum <= '0;
            s2_d   <= '0;
            s3_f   <= '0;
        end else begin
            if (in_en) begin
                s1_ab <= a + b;
                s1_cd <= c - d;
                s1_d  <= d;
            end
            if (s1_en) begin
                s2_sum <= s1_ab + s1_cd;
                s2_d   <= s1_d;
            end
            if (s2_en) begin
                s3_f <= s2_sum * s2_d;
            end
        end
    end

    assign f = s3_f;

endmodule

// File: rtl/alu_pipe_arbiter.sv
// Round-robin arbiter feeding a shared 3-cycle ALU pipeline; a tag shift
// register tracks ownership so each result strobes back to its requester.
module alu_pipe_arbiter
    import alu_pipe_arbiter_pkg::*;
#(
    parameter int N   = 10,
    parameter int LAT = LAT_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req0_c,
    input  logic [N-1:0] req0_d,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [N-1:0] req1_c,
    input  logic [N-1:0] req1_d,
    input  logic         issue_en,
    output logic         res0_valid,
    output logic         res1_valid,
    output logic [N-1:0] res_f,
    output logic         busy
);

    ptr_state_t ptr_q;
    ptr_state_t ptr_d;
    logic       grant0;
    logic       grant1;
    logic       xfer;
    req_id_t    sel_id;
    tag_t       tag_q [LAT];

    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] op_c;
    logic [N-1:0] op_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= LAST1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        ptr_d  = ptr_q;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && (!req1_valid || ptr_q == LAST1)) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
        req0_ready = rst_n && issue_en && grant0;
        req1_ready = rst_n && issue_en && grant1;
        if (req0_ready) begin
            ptr_d = LAST0;
        end else if (req1_ready) begin
            ptr_d = LAST1;
        end
    end

    assign xfer   = req0_ready || req1_ready;
    assign sel_id = req1_ready;

    always_comb begin
        op_a = req0_a;
        op_b = req0_b;
        op_c = req0_c;
        op_d = req0_d;
        if (sel_id) begin
            op_a = req1_a;
            op_b = req1_b;
            op_c = req1_c;
            op_d = req1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: xfer, id: sel_id};
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
        res0_valid = tag_q[LAT-1].valid && (tag_q[LAT-1].id == 1'b0);
        res1_valid = tag_q[LAT-1].valid && (tag_q[LAT-1].id == 1'b1);
    end

    alu_pipe_dp #(.N(N)) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .in_en (xfer),
        .s1_en (tag_q[0].valid),
        .s2_en (tag_q[1].valid),
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .d     (op_d),
        .f     (res_f)
    );

endmodule
